univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
Parametrised universal shift register for the FFT datapath. It supersedes the fixed 1-bit right-shift register and adds:
- multi-bit lanes and configurable depth
- right shift, left shift, parallel load and hold modes, plus a clock enable
- a fill counter that flags when a full word/frame has been assembled

Typical uses are serial-to-parallel sample capture, bit-reversal staging and delay lines feeding the butterfly.

Parameters:
LANE_W, 1, width in bits of one stage (lane); must be >= 1
DEPTH, 4, number of stages; must be >= 2
CNT_W, $clog2(DEPTH+1), localparam: fill-counter width, not overridable

Ports:
clk  input  1  rising-edge clock
clr_n  input  1  asynchronous active-low reset
clr  input  1  synchronous active-high clear
en  input  1  clock enable; when 0 all state holds
mode  input  2  operation select (encodings in package)
s_in_r  input  LANE_W  lane entering stage DEPTH-1 on right shift
s_in_l  input  LANE_W  lane entering stage 0 on left shift
pin  input  DEPTH*LANE_W  parallel load data, same stage layout as dout
dout  output  DEPTH*LANE_W  register contents; stage k = dout[(k+1)*LANE_W-1 : k*LANE_W]
s_out_r  output  LANE_W  stage 0 (lane shifted out on right shift)
s_out_l  output  LANE_W  stage DEPTH-1 (lane shifted out on left shift)
fill_cnt  output  CNT_W  shifts accumulated in current frame, 0..DEPTH
full  output  1  fill_cnt == DEPTH
frame_vld  output  1  one-cycle pulse: frame completed on previous edge

Behaviour:
- Reset (clr_n=0, asynchronous, overrides everything): dout=0, fill_cnt=0, frame_vld=0. Hence full=0, s_out_r=0, s_out_l=0.
- Priority at each rising edge: clr, then en=0, then mode.
- clr=1: dout=0, fill_cnt=0, frame_vld=0. Applies regardless of en.
- en=0: dout and fill_cnt hold; frame_vld=0.
- MODE_HOLD: dout and fill_cnt hold; frame_vld=0.
- MODE_SHR: stage i <= stage i+1 for i < DEPTH-1; stage DEPTH-1 <= s_in_r.
- MODE_SHL: stage i <= stage i-1 for i > 0; stage 0 <= s_in_l.
- MODE_LOAD: all stages <= pin; fill_cnt <= DEPTH; frame_vld <= 1.
- Fill counter on any shift (SHR or SHL):
  - fill_cnt < DEPTH-1: fill_cnt+1, frame_vld <= 0.
  - fill_cnt == DEPTH-1: fill_cnt <= DEPTH, frame_vld <= 1.
  - fill_cnt == DEPTH (wrap-around, new frame): fill_cnt <= 1, frame_vld <= 0.
- Latency:
  - dout and fill_cnt update one edge after the command.
  - frame_vld is registered and high in the cycle after the completing edge, coincident with the completed dout.
  - full and s_out_* are combinational decodes of registered state.
- Mixing SHR and SHL within a frame is legal; the counter counts both.
- Back-to-back LOAD keeps fill_cnt=DEPTH and re-pulses frame_vld each cycle.
- clr_n deasserted mid-frame: state restarts from zero; the partial frame is discarded and no frame_vld is produced.
- DEPTH=2 edge case: frame_vld at most every other shift; the wrap rule still holds.

Decomposition:
- Package univ_shift_pkg:
  - mode encodings MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11
  - width helper function for CNT_W
- Sub-module shift_fill_cnt (parameter DEPTH):
  - inputs: clk, clr_n, clr, shift strobe, load strobe
  - outputs: fill_cnt, full, frame_vld
- The stage array stays in univ_shift_reg.

Test Plan:
- Reset and single-lane shift (LANE_W=1, DEPTH=4): clr_n pulse -> dout=0, fill_cnt=0. Then SHR with s_in_r=1,0,1,1 -> dout=4'b1101, frame_vld high for 1 cycle after the 4th edge.
- Multi-lane left shift (LANE_W=8, DEPTH=4): SHL with s_in_l=0x11,0x22,0x33,0x44 -> dout=0x11223344, s_out_l=0x11, full=1.
- Wrap-around: after a full frame, one more SHR -> fill_cnt=1, full=0, frame_vld=0; 3 more SHR -> frame_vld pulses again.
- Load and priority: LOAD pin=0xA5 with en=1 -> dout=0xA5, frame_vld=1 next cycle. LOAD with en=0 -> no change. clr=1 with mode=LOAD -> dout=0, fill_cnt=0.
- Enable gaps: SHR alternating en=1/0 over 8 cycles -> fill_cnt advances only on en=1 edges, reaching 4 after the 4th enabled shift.
- Async reset mid-frame: fill_cnt=2, assert clr_n between edges -> outputs zero immediately with no clock; after release, 4 shifts needed for frame_vld.

Source files
------------

// File: rtl/univ_shift_pkg.sv
// univ_shift_pkg
// Shared definitions for the universal shift register:
//   - mode_e : operation select encodings driven on the 'mode' port
//   - cnt_width() : fill-counter width for a given stage count
package univ_shift_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // The counter must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/shift_fill_cnt.sv
// shift_fill_cnt
// Counts shifts accumulated in the current frame and pulses frame_vld on
// the cycle after the edge that completes a frame (or after a parallel load).
// Ports:
//   clk        rising-edge clock
//   clr_n      asynchronous active-low reset
//   clr        synchronous clear (highest synchronous priority)
//   shift_stb  a gated shift (SHR or SHL) happens on this edge
//   load_stb   a gated parallel load happens on this edge
//   fill_cnt   shifts in current frame, 0..DEPTH
//   full       fill_cnt == DEPTH
//   frame_vld  one-cycle pulse, frame completed on previous edge
module shift_fill_cnt
    import univ_shift_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             clr,
    input  logic             shift_stb,
    input  logic             load_stb,
    output logic [CNT_W-1:0] fill_cnt,
    output logic             full,
    output logic             frame_vld
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_vld;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt <= '0;
            r_vld <= 1'b0;
        end else if (clr) begin
            r_cnt <= '0;
            r_vld <= 1'b0;
        end else if (load_stb) begin
            r_cnt <= CNT_FULL;
            r_vld <= 1'b1;
        end else if (shift_stb) begin
            if (r_cnt == CNT_FULL) begin
                // First shift after a completed frame starts the next one.
                r_cnt <= CNT_ONE;
                r_vld <= 1'b0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt <= CNT_FULL;
                r_vld <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
                r_vld <= 1'b0;
            end
        end else begin
            r_vld <= 1'b0;
        end
    end

    assign fill_cnt  = r_cnt;
    assign full      = (r_cnt == CNT_FULL);
    assign frame_vld = r_vld;

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg
// Parametrised universal shift register: LANE_W-bit lanes, DEPTH stages,
// right/left shift, parallel load, hold, clock enable and frame fill counter.
// Ports:
//   clk, clr_n (async active-low reset), clr (sync clear), en (clock enable)
//   mode       operation select (mode_e)
//   s_in_r     lane entering stage DEPTH-1 on right shift
//   s_in_l     lane entering stage 0 on left shift
//   pin        parallel load data, stage k at [(k+1)*LANE_W-1 : k*LANE_W]
//   dout       register contents, same layout as pin
//   s_out_r    stage 0;  s_out_l  stage DEPTH-1
//   fill_cnt, full, frame_vld  from the fill counter
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int LANE_W = 1,
    parameter int DEPTH  = 4,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic                    clk,
    input  logic                    clr_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic [1:0]              mode,
    input  logic [LANE_W-1:0]       s_in_r,
    input  logic [LANE_W-1:0]       s_in_l,
    input  logic [DEPTH*LANE_W-1:0] pin,
    output logic [DEPTH*LANE_W-1:0] dout,
    output logic [LANE_W-1:0]       s_out_r,
    output logic [LANE_W-1:0]       s_out_l,
    output logic [CNT_W-1:0]        fill_cnt,
    output logic                    full,
    output logic                    frame_vld
);

    mode_e w_mode;
    logic  w_shift;
    logic  w_load;
    logic [LANE_W-1:0] w_stage [DEPTH];

    assign w_mode  = mode_e'(mode);
    assign w_shift = en && ((w_mode == MODE_SHR) || (w_mode == MODE_SHL));
    assign w_load  = en && (w_mode == MODE_LOAD);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [LANE_W-1:0] r_stage;
            logic [LANE_W-1:0] w_from_hi;   // source on right shift
            logic [LANE_W-1:0] w_from_lo;   // source on left shift

            if (gi == DEPTH - 1) begin : g_hi_edge
                assign w_from_hi = s_in_r;
            end else begin : g_hi_mid
                assign w_from_hi = w_stage[gi+1];
            end

            if (gi == 0) begin : g_lo_edge
                assign w_from_lo = s_in_l;
            end else begin : g_lo_mid
                assign w_from_lo = w_stage[gi-1];
            end

            always_ff @(posedge clk or negedge clr_n) begin
                if (!clr_n) begin
                    r_stage <= '0;
                end else if (clr) begin
                    r_stage <= '0;
                end else if (en) begin
                    case (w_mode)
                        MODE_SHR:  r_stage <= w_from_hi;
                        MODE_SHL:  r_stage <= w_from_lo;
                        MODE_LOAD: r_stage <= pin[gi*LANE_W +: LANE_W];
                        default:   r_stage <= r_stage;
                    endcase
                end
            end

            assign w_stage[gi]               = r_stage;
            assign dout[gi*LANE_W +: LANE_W] = r_stage;
        end
    endgenerate

    assign s_out_r = w_stage[0];
    assign s_out_l = w_stage[DEPTH-1];

    shift_fill_cnt #(
        .DEPTH(DEPTH)
    ) u_fill_cnt (
        .clk       (clk),
        .clr_n     (clr_n),
        .clr       (clr),
        .shift_stb (w_shift),
        .load_stb  (w_load),
        .fill_cnt  (fill_cnt),
        .full      (full),
        .frame_vld (frame_vld)
    );

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;
    import univ_shift_pkg::*;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic clr_n = 1'b1;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    // Instance A: LANE_W=1, DEPTH=4
    logic       a_en = 0;
    logic [1:0] a_mode = MODE_HOLD;
    logic       a_sr = 0, a_sl = 0;
    logic [3:0] a_pin = 0, a_dout;
    logic       a_sor, a_sol, a_full, a_vld;
    logic [2:0] a_cnt;

    // Instance B: LANE_W=8, DEPTH=4
    logic        b_en = 0;
    logic [1:0]  b_mode = MODE_HOLD;
    logic [7:0]  b_sr = 0, b_sl = 0, b_sor, b_sol;
    logic [31:0] b_pin = 0, b_dout;
    logic        b_full, b_vld;
    logic [2:0]  b_cnt;

    // Instance C: LANE_W=4, DEPTH=2
    logic       c_en = 0;
    logic [1:0] c_mode = MODE_HOLD;
    logic [3:0] c_sr = 0, c_sl = 0, c_sor, c_sol;
    logic [7:0] c_pin = 0, c_dout;
    logic       c_full, c_vld;
    logic [1:0] c_cnt;

    univ_shift_reg #(.LANE_W(1), .DEPTH(4)) u_a (
        .clk(clk), .clr_n(clr_n), .clr(clr), .en(a_en), .mode(a_mode),
        .s_in_r(a_sr), .s_in_l(a_sl), .pin(a_pin), .dout(a_dout),
        .s_out_r(a_sor), .s_out_l(a_sol), .fill_cnt(a_cnt), .full(a_full),
        .frame_vld(a_vld));

    univ_shift_reg #(.LANE_W(8), .DEPTH(4)) u_b (
        .clk(clk), .clr_n(clr_n), .clr(clr), .en(b_en), .mode(b_mode),
        .s_in_r(b_sr), .s_in_l(b_sl), .pin(b_pin), .dout(b_dout),
        .s_out_r(b_sor), .s_out_l(b_sol), .fill_cnt(b_cnt), .full(b_full),
        .frame_vld(b_vld));

    univ_shift_reg #(.LANE_W(4), .DEPTH(2)) u_c (
        .clk(clk), .clr_n(clr_n), .clr(clr), .en(c_en), .mode(c_mode),
        .s_in_r(c_sr), .s_in_l(c_sl), .pin(c_pin), .dout(c_dout),
        .s_out_r(c_sor), .s_out_l(c_sol), .fill_cnt(c_cnt), .full(c_full),
        .frame_vld(c_vld));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- async reset at start ----------------
        #2 clr_n = 1'b0;
        #1;
        check("rst_a_dout", 64'(a_dout), 64'h0);
        check("rst_a_cnt",  64'(a_cnt),  64'h0);
        check("rst_a_full", 64'(a_full), 64'h0);
        check("rst_a_vld",  64'(a_vld),  64'h0);
        check("rst_b_sor",  64'(b_sor),  64'h0);
        check("rst_b_sol",  64'(b_sol),  64'h0);
        check("rst_c_dout", 64'(c_dout), 64'h0);
        #8 clr_n = 1'b1;             // released at t=11, away from edges
        tick();

        // ---------------- A: single-lane right shift ----------------
        a_en = 1; a_mode = MODE_SHR;
        a_sr = 1; tick();
        check("a_shr1_dout", 64'(a_dout), 64'h8);
        check("a_shr1_cnt",  64'(a_cnt),  64'd1);
        a_sr = 0; tick();
        check("a_shr2_dout", 64'(a_dout), 64'h4);
        a_sr = 1; tick();
        check("a_shr3_dout", 64'(a_dout), 64'hA);
        check("a_shr3_vld",  64'(a_vld),  64'h0);
        a_sr = 1; tick();
        check("a_shr4_dout", 64'(a_dout), 64'hD);
        check("a_shr4_cnt",  64'(a_cnt),  64'd4);
        check("a_shr4_full", 64'(a_full), 64'h1);
        check("a_shr4_vld",  64'(a_vld),  64'h1);
        check("a_shr4_sor",  64'(a_sor),  64'h1);
        check("a_shr4_sol",  64'(a_sol),  64'h1);
        a_mode = MODE_HOLD; tick();
        check("a_hold_vld",  64'(a_vld),  64'h0);
        check("a_hold_dout", 64'(a_dout), 64'hD);
        check("a_hold_cnt",  64'(a_cnt),  64'd4);

        // ---------------- A: wrap-around ----------------
        a_mode = MODE_SHR; a_sr = 0; tick();
        check("a_wrap_cnt",  64'(a_cnt),  64'd1);
        check("a_wrap_full", 64'(a_full), 64'h0);
        check("a_wrap_vld",  64'(a_vld),  64'h0);
        check("a_wrap_dout", 64'(a_dout), 64'h6);
        tick();
        tick();
        check("a_wrap3_vld", 64'(a_vld),  64'h0);
        check("a_wrap3_cnt", 64'(a_cnt),  64'd3);
        tick();
        check("a_wrap4_vld", 64'(a_vld),  64'h1);
        check("a_wrap4_dout",64'(a_dout), 64'h0);

        // ---------------- A: clr beats LOAD ----------------
        a_mode = MODE_LOAD; a_pin = 4'hF; clr = 1; tick();
        check("a_clr_dout",  64'(a_dout), 64'h0);
        check("a_clr_cnt",   64'(a_cnt),  64'd0);
        check("a_clr_vld",   64'(a_vld),  64'h0);
        clr = 0;

        // ---------------- A: enable gaps ----------------
        a_mode = MODE_SHR; a_sr = 1;
        for (int i = 0; i < 8; i++) begin
            a_en = (i % 2 == 0);
            tick();
            check($sformatf("a_gap%0d_cnt", i), 64'(a_cnt), 64'(i / 2 + 1));
            check($sformatf("a_gap%0d_vld", i), 64'(a_vld), 64'(i == 6));
        end
        check("a_gap_dout",  64'(a_dout), 64'hF);

        // ---------------- A: load, back-to-back load, gated load ----------------
        a_en = 1; a_mode = MODE_LOAD; a_pin = 4'h5; tick();
        check("a_ld1_dout",  64'(a_dout), 64'h5);
        check("a_ld1_cnt",   64'(a_cnt),  64'd4);
        check("a_ld1_vld",   64'(a_vld),  64'h1);
        a_pin = 4'hA; tick();
        check("a_ld2_dout",  64'(a_dout), 64'hA);
        check("a_ld2_vld",   64'(a_vld),  64'h1);
        a_en = 0; a_pin = 4'h3; tick();
        check("a_ld3_dout",  64'(a_dout), 64'hA);
        check("a_ld3_vld",   64'(a_vld),  64'h0);
        check("a_ld3_cnt",   64'(a_cnt),  64'd4);
        a_mode = MODE_HOLD;

        // ---------------- B: multi-lane left shift ----------------
        b_en = 1; b_mode = MODE_SHL;
        b_sl = 8'h11; tick();
        b_sl = 8'h22; tick();
        b_sl = 8'h33; tick();
        check("b_shl3_vld",  64'(b_vld),  64'h0);
        b_sl = 8'h44; tick();
        check("b_shl_dout",  64'(b_dout), 64'h11223344);
        check("b_shl_sol",   64'(b_sol),  64'h11);
        check("b_shl_sor",   64'(b_sor),  64'h44);
        check("b_shl_full",  64'(b_full), 64'h1);
        check("b_shl_vld",   64'(b_vld),  64'h1);

        b_mode = MODE_LOAD; b_pin = 32'h000000A5; tick();
        check("b_ld_dout",   64'(b_dout), 64'hA5);
        check("b_ld_vld",    64'(b_vld),  64'h1);

        // mixed directions within one frame
        b_mode = MODE_SHR; b_sr = 8'hFF; tick();
        check("b_mix1_dout", 64'(b_dout), 64'hFF000000);
        check("b_mix1_cnt",  64'(b_cnt),  64'd1);
        b_mode = MODE_SHL; b_sl = 8'h5A; tick();
        check("b_mix2_dout", 64'(b_dout), 64'h0000005A);
        check("b_mix2_cnt",  64'(b_cnt),  64'd2);
        b_mode = MODE_HOLD;

        // ---------------- async reset mid-frame (no clock edge) ----------------
        #3 clr_n = 1'b0;
        #1;
        check("arst_b_dout", 64'(b_dout), 64'h0);
        check("arst_b_cnt",  64'(b_cnt),  64'd0);
        check("arst_a_dout", 64'(a_dout), 64'h0);
        check("arst_a_full", 64'(a_full), 64'h0);
        #2 clr_n = 1'b1;
        b_mode = MODE_SHL;
        for (int i = 0; i < 4; i++) begin
            b_sl = 8'(i + 1);
            tick();
            check($sformatf("b_rf%0d_cnt", i), 64'(b_cnt), 64'(i + 1));
            check($sformatf("b_rf%0d_vld", i), 64'(b_vld), 64'(i == 3));
        end
        check("b_rf_dout",   64'(b_dout), 64'h01020304);
        b_mode = MODE_HOLD;

        // ---------------- C: DEPTH=2 edge case ----------------
        c_en = 1; c_mode = MODE_SHR;
        c_sr = 4'h3; tick();
        check("c1_cnt",  64'(c_cnt), 64'd1);
        check("c1_vld",  64'(c_vld), 64'h0);
        c_sr = 4'h7; tick();
        check("c2_dout", 64'(c_dout), 64'h73);
        check("c2_full", 64'(c_full), 64'h1);
        check("c2_vld",  64'(c_vld),  64'h1);
        c_sr = 4'h9; tick();
        check("c3_dout", 64'(c_dout), 64'h97);
        check("c3_cnt",  64'(c_cnt),  64'd1);
        check("c3_vld",  64'(c_vld),  64'h0);
        c_sr = 4'h1; tick();
        check("c4_dout", 64'(c_dout), 64'h19);
        check("c4_vld",  64'(c_vld),  64'h1);
        check("c4_sor",  64'(c_sor),  64'h9);
        check("c4_sol",  64'(c_sol),  64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
